// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and the totals/sync positions derived from them.
package vga_timing_pkg;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Inclusive window test used for the sync pulses.
  function automatic logic in_window(logic [9:0] pos, logic [9:0] first, logic [9:0] last);
    return (pos >= first) && (pos <= last);
  endfunction
endpackage

// File: rtl/vga_scan_ctrl_pix_ce_gen.sv
// Divide-by-four pixel enable; the fabric stays on clk_100mhz, pix_ce only gates flops.
module pix_ce_gen (
  input  logic clk_100mhz,
  input  logic rst,
  output logic pix_ce
);
  logic [1:0] div;

  always_ff @(posedge clk_100mhz or negedge rst)
    if (!rst) div <= '0;
    else      div <= div + 2'd1;

  // Fires on the cycle before the 4th edge after reset release.
  assign pix_ce = (div == 2'd3);
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pixel/line counters, address generation and a one-pixel colour/sync pipeline.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic [11:0] d_in,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        rdn
);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       pix_ce;
  logic [9:0] h_cnt, v_cnt;
  logic       visible, hsync_raw, vsync_raw;

  pix_ce_gen u_pix_ce (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .pix_ce     (pix_ce)
  );

  always_ff @(posedge clk_100mhz or negedge rst)
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end

  assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_raw = !in_window(h_cnt, HS_FIRST, HS_LAST);
  assign vsync_raw = !in_window(v_cnt, VS_FIRST, VS_LAST);

  // Address follows the counters so d_in settles during the pixel it is sampled at.
  assign col_addr    = visible ? h_cnt : '0;
  assign row_addr    = visible ? v_cnt[8:0] : '0;
  assign frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk_100mhz or negedge rst)
    if (!rst) begin
      {r, g, b} <= '0;
      hs        <= 1'b1;
      vs        <= 1'b1;
      rdn       <= 1'b1;
    end else if (pix_ce) begin
      {r, g, b} <= visible ? d_in : 12'd0;
      hs        <= hsync_raw;
      vs        <= vsync_raw;
      rdn       <= !visible;
    end
endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33; all counted in lines.
REQ-007 SHALL have port clk_100mhz  input  1  system clock; the only clock in the block.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port d_in  input  12  pixel colour {r[3:0],g[3:0],b[3:0]} for the current address.
REQ-010 SHALL have port row_addr  output  9  visible line index, 0..479.
REQ-011 SHALL have port col_addr  output  10  visible pixel index, 0..639.
REQ-012 SHALL have port r, g, b  output  4 each  colour to the DAC.
REQ-013 SHALL have port hs, vs  output  1 each  active-low sync pulses.
REQ-014 SHALL have port frame_start  output  1  one-clk_100mhz strobe at pixel (0,0) of each frame.
REQ-015 SHALL have port rdn  output  1  low while the current pixel is visible.

Function
REQ-016 SHALL derive pixel enable pix_ce from a free-running 2-bit counter; pix_ce is high one clk_100mhz cycle in four, giving 25 MHz. No derived clock drives any flop.
REQ-017 h_cnt SHALL count 0..799 on pix_ce and wrap to 0. v_cnt SHALL increment on pix_ce when h_cnt==799, counting 0..524 and wrapping to 0.
REQ-018 visible SHALL equal (h_cnt<H_VISIBLE)&&(v_cnt<V_VISIBLE).
REQ-019 col_addr and row_addr SHALL equal h_cnt and v_cnt while visible, and SHALL hold 0 outside the visible region.
REQ-020 Raw hsync SHALL be low for h_cnt in [656,751]; raw vsync SHALL be low for v_cnt in [490,491].
REQ-021 Pipeline latency SHALL be one pixel. On pix_ce, the block registers d_in (gated to 0 when not visible) into r/g/b and registers raw hsync, vsync and ~visible into hs, vs and rdn. Colour and sync therefore stay aligned with the address.
REQ-022 d_in SHALL be treated as combinational from row_addr/col_addr and SHALL be sampled only on the pix_ce cycle.
REQ-023 r/g/b SHALL be 0 on every pixel where the registered rdn is 1.
REQ-024 frame_start SHALL pulse for exactly one clk_100mhz cycle, on the pix_ce where h_cnt==0 and v_cnt==0.
REQ-025 All outputs SHALL change only on pix_ce cycles, except frame_start.
REQ-026 On the pixel after h_cnt=799, v_cnt=524, the counters SHALL read h_cnt=0, v_cnt=0 with no extra blank pixel.

Reset
REQ-027 While rst=0, all of the following SHALL be 0: divider, h_cnt, v_cnt, row_addr, col_addr, r, g, b, frame_start.
REQ-028 While rst=0, hs, vs and rdn SHALL be 1 (inactive/blank).
REQ-029 Reset asserted mid-frame SHALL clear the state immediately, without waiting for a clock edge.
REQ-030 After release, the first pix_ce SHALL occur on the 4th rising edge, and the scan SHALL restart at pixel (0,0) with a frame_start pulse.

Structure
REQ-031 Timing defaults and the derived totals (H_TOTAL=800, V_TOTAL=525, sync start/end positions) SHALL live in shared package vga_timing_pkg.
REQ-032 The pixel enable divider SHALL be the single sub-module pix_ce_gen, with ports clk_100mhz, rst and pix_ce.

Verification
REQ-033 Reset released, run 4*800 clocks -> exactly one pix_ce per 4 clocks. hs low for 96 pixels starting at pixel 657 of the line (one-pixel delay). rdn low for pixels 1..640.
REQ-034 Run one full frame -> 525 hs pulses. vs low during lines 490..491, delayed by one pixel. frame_start pulses exactly once per 420000 pix_ce.
REQ-035 d_in driven as {row_addr[3:0],col_addr[3:0],4'hA} -> r/g/b on pixel k+1 equals the value driven for address k. Outputs are 0 during blanking even with d_in=12'hFFF.
REQ-036 Address at pixel (479,639) -> next pixel row_addr=0, col_addr=0, rdn=1. Wrap at (524,799) -> next pixel is (0,0) with frame_start=1.
REQ-037 rst pulsed low mid-line at h_cnt=300, v_cnt=200 -> all outputs reach their reset values asynchronously. After release the scan restarts at (0,0) with frame_start=1.
